ycbcr_stream_converter: RTL and testbench

YCBCR_STREAM_CONVERTER -- requirements
Module: ycbcr_stream_converter

---
 rtl/ycbcr_pkg.sv | 83 ++++++++
 rtl/ycbcr_stream_converter_mac.sv | 114 +++++++++++
 rtl/ycbcr_stream_converter.sv | 114 +++++++++++
 tb/tb_ycbcr_stream_converter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants for the RGB -> YCbCr stream converter.
//
// Holds the real-valued conversion coefficients and offsets for both
// colour ranges, the mode and channel enums, and constant functions that
// turn them into fixed-point values for a given number of fractional bits.
package ycbcr_pkg;

  typedef enum logic {
    FULL_RANGE   = 1'b0,  // JPEG full range
    STUDIO_RANGE = 1'b1   // BT.601 studio range
  } ycbcr_mode_e;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } ycbcr_chan_e;

  // Full range (JPEG) coefficients, ordered R, G, B.
  localparam real Y_FULL_R  =  0.299;
  localparam real Y_FULL_G  =  0.587;
  localparam real Y_FULL_B  =  0.114;
  localparam real CB_FULL_R = -0.168736;
  localparam real CB_FULL_G = -0.331264;
  localparam real CB_FULL_B =  0.5;
  localparam real CR_FULL_R =  0.5;
  localparam real CR_FULL_G = -0.418688;
  localparam real CR_FULL_B = -0.081312;

  // Studio range (BT.601) coefficients, ordered R, G, B.
  localparam real Y_STUDIO_R  =  0.256788;
  localparam real Y_STUDIO_G  =  0.504129;
  localparam real Y_STUDIO_B  =  0.097906;
  localparam real CB_STUDIO_R = -0.148223;
  localparam real CB_STUDIO_G = -0.290993;
  localparam real CB_STUDIO_B =  0.439216;
  localparam real CR_STUDIO_R =  0.439216;
  localparam real CR_STUDIO_G = -0.367788;
  localparam real CR_STUDIO_B = -0.071427;

  // Integer offsets, applied shifted up by the fractional bit count.
  localparam int Y_FULL_OFFSET   = 0;
  localparam int Y_STUDIO_OFFSET = 16;
  localparam int CHROMA_OFFSET   = 128;

  function automatic real coef_real(input ycbcr_mode_e mode, input ycbcr_chan_e chan,
                                    input int tap);
    real c;
    c = 0.0;
    if (mode == FULL_RANGE) begin
      case (chan)
        CH_Y:    c = (tap == 0) ? Y_FULL_R  : (tap == 1) ? Y_FULL_G  : Y_FULL_B;
        CH_CB:   c = (tap == 0) ? CB_FULL_R : (tap == 1) ? CB_FULL_G : CB_FULL_B;
        default: c = (tap == 0) ? CR_FULL_R : (tap == 1) ? CR_FULL_G : CR_FULL_B;
      endcase
    end else begin
      case (chan)
        CH_Y:    c = (tap == 0) ? Y_STUDIO_R  : (tap == 1) ? Y_STUDIO_G  : Y_STUDIO_B;
        CH_CB:   c = (tap == 0) ? CB_STUDIO_R : (tap == 1) ? CB_STUDIO_G : CB_STUDIO_B;
        default: c = (tap == 0) ? CR_STUDIO_R : (tap == 1) ? CR_STUDIO_G : CR_STUDIO_B;
      endcase
    end
    return c;
  endfunction

  // round(c * 2^scale); the real-to-integer cast rounds to nearest.
  function automatic longint coef_fixed(input ycbcr_mode_e mode, input ycbcr_chan_e chan,
                                        input int tap, input int scale);
    real f;
    f = 1.0;
    for (int i = 0; i < scale; i++) f = f * 2.0;
    return longint'(coef_real(mode, chan, tap) * f);
  endfunction

  function automatic longint offset_fixed(input ycbcr_mode_e mode, input ycbcr_chan_e chan,
                                          input int scale);
    int off;
    if (chan == CH_Y) off = (mode == FULL_RANGE) ? Y_FULL_OFFSET : Y_STUDIO_OFFSET;
    else              off = CHROMA_OFFSET;
    return longint'(off) << scale;
  endfunction

endpackage

// File: rtl/ycbcr_stream_converter_mac.sv
// One output channel of the RGB -> YCbCr converter.
//
// Three pipeline stages, each loaded by its own enable from the top-level
// flow control:
//   p0: three signed coefficient products (coefficients picked by mode_in)
//   p1: signed sum of the products
//   p2: offset added (picked by mode_p1), saturated, registered as result
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (result only)
//   en_p0/en_p1/en_p2   stage load enables
//   mode_in             range mode of the pixel entering p0
//   mode_p1             range mode of the pixel held in p1
//   r_in, g_in, b_in    unsigned colour components
//   res_out             unsigned fixed-point result, SCALE fractional bits
module ycbcr_coef_mac
  import ycbcr_pkg::*;
#(
  parameter ycbcr_chan_e CHAN               = CH_Y,
  parameter int          SCALE              = 16,
  parameter int          FIXED_POINT_LENGTH = 32,
  parameter int          INPUT_WIDTH        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_p0,
  input  logic                          en_p1,
  input  logic                          en_p2,
  input  logic                          mode_in,
  input  logic                          mode_p1,
  input  logic [INPUT_WIDTH-1:0]        r_in,
  input  logic [INPUT_WIDTH-1:0]        g_in,
  input  logic [INPUT_WIDTH-1:0]        b_in,
  output logic [FIXED_POINT_LENGTH-1:0] res_out
);

  // Coefficients are below 1.0 in magnitude, so SCALE+2 signed bits suffice.
  localparam int COEF_W = SCALE + 2;
  localparam int PROD_W = INPUT_WIDTH + 1 + COEF_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int OFF_W  = SCALE + INPUT_WIDTH + 2;
  localparam int ACC_W  = ((SUM_W > OFF_W) ? SUM_W : OFF_W) + 1;

  localparam logic signed [COEF_W-1:0] KF_R = COEF_W'(coef_fixed(FULL_RANGE,   CHAN, 0, SCALE));
  localparam logic signed [COEF_W-1:0] KF_G = COEF_W'(coef_fixed(FULL_RANGE,   CHAN, 1, SCALE));
  localparam logic signed [COEF_W-1:0] KF_B = COEF_W'(coef_fixed(FULL_RANGE,   CHAN, 2, SCALE));
  localparam logic signed [COEF_W-1:0] KS_R = COEF_W'(coef_fixed(STUDIO_RANGE, CHAN, 0, SCALE));
  localparam logic signed [COEF_W-1:0] KS_G = COEF_W'(coef_fixed(STUDIO_RANGE, CHAN, 1, SCALE));
  localparam logic signed [COEF_W-1:0] KS_B = COEF_W'(coef_fixed(STUDIO_RANGE, CHAN, 2, SCALE));

  localparam logic signed [ACC_W-1:0] OFF_F = ACC_W'(offset_fixed(FULL_RANGE,   CHAN, SCALE));
  localparam logic signed [ACC_W-1:0] OFF_S = ACC_W'(offset_fixed(STUDIO_RANGE, CHAN, SCALE));

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'(((longint'(1) << INPUT_WIDTH) - longint'(1)) << SCALE);

  function automatic logic [FIXED_POINT_LENGTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic [FIXED_POINT_LENGTH-1:0] r;
    if (v < 0)            r = '0;
    else if (v > SAT_MAX) r = FIXED_POINT_LENGTH'(SAT_MAX);
    else                  r = FIXED_POINT_LENGTH'(v);
    return r;
  endfunction

  logic signed [COEF_W-1:0] k_r, k_g, k_b;
  logic signed [PROD_W-1:0] mul_r, mul_g, mul_b;
  logic signed [PROD_W-1:0] prod_r_p0, prod_g_p0, prod_b_p0;
  logic signed [SUM_W-1:0]  sum_p1;
  logic signed [ACC_W-1:0]  acc;
  logic [FIXED_POINT_LENGTH-1:0] res_p2;

  always_comb begin
    if (ycbcr_mode_e'(mode_in) == STUDIO_RANGE) begin
      k_r = KS_R;
      k_g = KS_G;
      k_b = KS_B;
    end else begin
      k_r = KF_R;
      k_g = KF_G;
      k_b = KF_B;
    end
    // Both operands widened before multiplying so the product is full width.
    mul_r = PROD_W'(signed'({1'b0, r_in})) * PROD_W'(k_r);
    mul_g = PROD_W'(signed'({1'b0, g_in})) * PROD_W'(k_g);
    mul_b = PROD_W'(signed'({1'b0, b_in})) * PROD_W'(k_b);
  end

  // ---- stage p0: products ----
  always_ff @(posedge clk) begin
    if (en_p0) begin
      prod_r_p0 <= mul_r;
      prod_g_p0 <= mul_g;
      prod_b_p0 <= mul_b;
    end
  end

  // ---- stage p1: signed sum ----
  always_ff @(posedge clk) begin
    if (en_p1) sum_p1 <= SUM_W'(prod_r_p0) + SUM_W'(prod_g_p0) + SUM_W'(prod_b_p0);
  end

  always_comb begin
    acc = ACC_W'(sum_p1) + ((ycbcr_mode_e'(mode_p1) == STUDIO_RANGE) ? OFF_S : OFF_F);
  end

  // ---- stage p2: offset, saturate, output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     res_p2 <= '0;
    else if (en_p2) res_p2 <= saturate(acc);
  end

  assign res_out = res_p2;

endmodule

// File: rtl/ycbcr_stream_converter.sv
// Streaming RGB -> YCbCr converter with valid/ready handshakes.
//
// Three-stage pipeline, one valid bit per stage; a stage loads when it is
// empty or when its successor loads, so bubbles collapse and a stalled
// output freezes the whole pipe. Mode and user tag ride with each pixel.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      input handshake
//   r_in, g_in, b_in         unsigned colour components
//   mode_in                  0 = full range, 1 = studio range (per pixel)
//   user_in                  sideband tag, passed through
//   out_valid / out_ready    output handshake
//   y_out, cb_out, cr_out    unsigned fixed point, SCALE fractional bits
//   user_out                 tag of the pixel on the outputs
module ycbcr_stream_converter
  import ycbcr_pkg::*;
#(
  parameter int SCALE              = 16,
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int INPUT_WIDTH        = 8,
  parameter int USER_WIDTH         = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INPUT_WIDTH-1:0]        r_in,
  input  logic [INPUT_WIDTH-1:0]        g_in,
  input  logic [INPUT_WIDTH-1:0]        b_in,
  input  logic                          mode_in,
  input  logic [USER_WIDTH-1:0]         user_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIXED_POINT_LENGTH-1:0] y_out,
  output logic [FIXED_POINT_LENGTH-1:0] cb_out,
  output logic [FIXED_POINT_LENGTH-1:0] cr_out,
  output logic [USER_WIDTH-1:0]         user_out
);

  logic vld_p0, vld_p1, vld_p2;
  logic adv_p0, adv_p1, adv_p2;
  logic mode_p0, mode_p1;
  logic [USER_WIDTH-1:0] user_p0, user_p1, user_p2;

  // Load enables ripple back from the output within one cycle.
  always_comb begin
    adv_p2 = !vld_p2 || out_ready;
    adv_p1 = !vld_p1 || adv_p2;
    adv_p0 = !vld_p0 || adv_p1;
  end

  assign in_ready  = adv_p0;
  assign out_valid = vld_p2;
  assign user_out  = user_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p0) vld_p0 <= in_valid;
      if (adv_p1) vld_p1 <= vld_p0;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage p0 / p1: sideband data ----
  always_ff @(posedge clk) begin
    if (adv_p0) begin
      mode_p0 <= mode_in;
      user_p0 <= user_in;
    end
    if (adv_p1) begin
      mode_p1 <= mode_p0;
      user_p1 <= user_p0;
    end
  end

  // ---- stage p2: output tag, cleared by reset with the other outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      user_p2 <= '0;
    else if (adv_p2) user_p2 <= user_p1;
  end

  ycbcr_coef_mac #(
    .CHAN(CH_Y), .SCALE(SCALE), .FIXED_POINT_LENGTH(FIXED_POINT_LENGTH),
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_mac_y (
    .clk(clk), .rst_n(rst_n), .en_p0(adv_p0), .en_p1(adv_p1), .en_p2(adv_p2),
    .mode_in(mode_in), .mode_p1(mode_p1),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .res_out(y_out)
  );

  ycbcr_coef_mac #(
    .CHAN(CH_CB), .SCALE(SCALE), .FIXED_POINT_LENGTH(FIXED_POINT_LENGTH),
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_mac_cb (
    .clk(clk), .rst_n(rst_n), .en_p0(adv_p0), .en_p1(adv_p1), .en_p2(adv_p2),
    .mode_in(mode_in), .mode_p1(mode_p1),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .res_out(cb_out)
  );

  ycbcr_coef_mac #(
    .CHAN(CH_CR), .SCALE(SCALE), .FIXED_POINT_LENGTH(FIXED_POINT_LENGTH),
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_mac_cr (
    .clk(clk), .rst_n(rst_n), .en_p0(adv_p0), .en_p1(adv_p1), .en_p2(adv_p2),
    .mode_in(mode_in), .mode_p1(mode_p1),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .res_out(cr_out)
  );

endmodule

// File: tb/tb_ycbcr_stream_converter.sv
module tb_ycbcr_stream_converter;

  localparam int SCALE = 16;
  localparam int FPL   = 32;
  localparam int IW    = 8;
  localparam int UW    = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  r_in, g_in, b_in;
  logic           mode_in;
  logic [UW-1:0]  user_in;
  logic           out_valid;
  logic           out_ready;
  logic [FPL-1:0] y_out, cb_out, cr_out;
  logic [UW-1:0]  user_out;

  always #5 clk = ~clk;

  ycbcr_stream_converter #(
    .SCALE(SCALE), .FIXED_POINT_LENGTH(FPL), .INPUT_WIDTH(IW), .USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .mode_in(mode_in), .user_in(user_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .cb_out(cb_out), .cr_out(cr_out), .user_out(user_out)
  );

  typedef struct {
    logic          mode;
    logic [7:0]    r, g, b;
    logic [1:0]    user;
    logic [31:0]   ey, ecb, ecr;
  } vec_t;

  typedef struct packed {
    logic [31:0] y, cb, cr;
    logic [1:0]  u;
  } exp_t;

  vec_t vecs[7];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, act, req, req);
    end
  endtask

  // Reference coefficients written out independently of the design package.
  function automatic real bc(input logic m, input int ch, input int k);
    real t[3];
    if (!m) begin
      if (ch == 0)      t = '{0.299, 0.587, 0.114};
      else if (ch == 1) t = '{-0.168736, -0.331264, 0.5};
      else              t = '{0.5, -0.418688, -0.081312};
    end else begin
      if (ch == 0)      t = '{0.256788, 0.504129, 0.097906};
      else if (ch == 1) t = '{-0.148223, -0.290993, 0.439216};
      else              t = '{0.439216, -0.367788, -0.071427};
    end
    return t[k];
  endfunction

  function automatic longint q(input real c);
    return longint'(c * 65536.0);
  endfunction

  function automatic logic [31:0] ref_chan(input logic m, input int ch, input int r,
                                           input int g, input int b);
    longint acc, cap;
    int off;
    acc = q(bc(m, ch, 0)) * r + q(bc(m, ch, 1)) * g + q(bc(m, ch, 2)) * b;
    off = (ch == 0) ? (m ? 16 : 0) : 128;
    acc = acc + (longint'(off) << SCALE);
    cap = longint'(255) << SCALE;
    if (acc < 0) acc = 0;
    else if (acc > cap) acc = cap;
    return acc[31:0];
  endfunction

  // Single pixel with out_ready high: checks exact 3-cycle latency and values.
  task automatic apply_vec(input vec_t v, input int idx);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mode_in   = v.mode;
    r_in      = v.r;
    g_in      = v.g;
    b_in      = v.b;
    user_in   = v.user;
    chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_early_valid", idx), 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d_y", idx), y_out, v.ey);
    chk($sformatf("v%0d_cb", idx), cb_out, v.ecb);
    chk($sformatf("v%0d_cr", idx), cr_out, v.ecr);
    chk($sformatf("v%0d_user", idx), 32'(user_out), 32'(v.user));
    @(posedge clk); #1;
    chk($sformatf("v%0d_drained", idx), 32'(out_valid), 32'd0);
  endtask

  // kind 0: random gaps and random backpressure
  // kind 1: full rate, alternating mode and user tag
  // kind 2: output blocked for the first 8 cycles, then released
  task automatic run_stream(input int n, input int kind);
    exp_t exq[$];
    exp_t e, held;
    int sent, got, cyc;
    logic acc, stall_prev;
    sent = 0; got = 0; cyc = 0; acc = 1'b0; stall_prev = 1'b0;
    held = '0;
    in_valid = 1'b0;
    while (got < n && cyc < 600) begin
      if (!in_valid && sent < n && (kind != 0 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        r_in = 8'($urandom_range(0, 255));
        g_in = 8'($urandom_range(0, 255));
        b_in = 8'($urandom_range(0, 255));
        if (kind == 1) begin
          mode_in = sent[0];
          user_in = 2'(sent);
        end else begin
          mode_in = 1'($urandom_range(0, 1));
          user_in = 2'($urandom_range(0, 3));
        end
      end
      if (kind == 0)      out_ready = 1'($urandom_range(0, 1));
      else if (kind == 1) out_ready = 1'b1;
      else                out_ready = (cyc >= 8);
      @(negedge clk);
      if (kind == 2 && cyc == 6) begin
        chk("full_stall_in_ready", 32'(in_ready), 32'd0);
        chk("full_stall_accepted", 32'(sent), 32'd3);
      end
      if (stall_prev) begin
        chk($sformatf("k%0d_hold_valid", kind), 32'(out_valid), 32'd1);
        chk($sformatf("k%0d_hold_y", kind), y_out, held.y);
        chk($sformatf("k%0d_hold_cb", kind), cb_out, held.cb);
        chk($sformatf("k%0d_hold_cr", kind), cr_out, held.cr);
        chk($sformatf("k%0d_hold_user", kind), 32'(user_out), 32'(held.u));
      end
      if (out_valid && out_ready) begin
        if (exq.size() == 0) begin
          chk($sformatf("k%0d_extra_output", kind), 32'd1, 32'd0);
        end else begin
          e = exq.pop_front();
          chk($sformatf("k%0d_p%0d_y", kind, got), y_out, e.y);
          chk($sformatf("k%0d_p%0d_cb", kind, got), cb_out, e.cb);
          chk($sformatf("k%0d_p%0d_cr", kind, got), cr_out, e.cr);
          chk($sformatf("k%0d_p%0d_user", kind, got), 32'(user_out), 32'(e.u));
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held = '{y_out, cb_out, cr_out, user_out};
      acc = in_valid && in_ready;
      if (acc) begin
        e.y  = ref_chan(mode_in, 0, r_in, g_in, b_in);
        e.cb = ref_chan(mode_in, 1, r_in, g_in, b_in);
        e.cr = ref_chan(mode_in, 2, r_in, g_in, b_in);
        e.u  = user_in;
        exq.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk($sformatf("k%0d_all_received", kind), 32'(got), 32'(n));
    chk($sformatf("k%0d_queue_empty", kind), 32'(exq.size()), 32'd0);
    if (kind == 1) chk("full_rate_cycles_ok", 32'(cyc <= n + 4), 32'd1);
  endtask

  initial begin
    logic stale;
    vecs[0] = '{1'b0, 8'd255, 8'd255, 8'd255, 2'd1, 32'h00FF0000, 32'h00800000, 32'h00800000};
    vecs[1] = '{1'b0, 8'd0,   8'd0,   8'd0,   2'd2, 32'h00000000, 32'h00800000, 32'h00800000};
    vecs[2] = '{1'b1, 8'd0,   8'd0,   8'd0,   2'd3, 32'h00100000, 32'h00800000, 32'h00800000};
    vecs[3] = '{1'b0, 8'd255, 8'd0,   8'd0,   2'd0, 32'd4996725,  32'd5568818,  32'd16711680};
    vecs[4] = '{1'b0, 8'd0,   8'd255, 8'd0,   2'd1, 32'd9809850,  32'd2852558,  32'd1391663};
    vecs[5] = '{1'b0, 8'd0,   8'd0,   8'd255, 2'd2, 32'd1905105,  32'd16711680, 32'd7029713};
    vecs[6] = '{1'b1, 8'd255, 8'd255, 8'd255, 2'd3, 32'd15400996, 32'd8388353,  32'd8388608};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    r_in = '0; g_in = '0; b_in = '0; mode_in = 1'b0; user_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y_out, 32'd0);
    chk("rst_cb", cb_out, 32'd0);
    chk("rst_cr", cr_out, 32'd0);
    chk("rst_user", 32'(user_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], i);

    run_stream(20, 0);
    run_stream(8, 1);
    run_stream(6, 2);

    // Reset with three pixels in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; mode_in = 1'b0; user_in = 2'(i + 1);
      r_in = 8'd200; g_in = 8'(i * 40); b_in = 8'd10;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_y", y_out, 32'd0);
    chk("midrst_user", 32'(user_out), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", 32'(in_ready), 32'd1);
    stale = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      stale = stale | out_valid;
    end
    chk("no_stale_pixel", 32'(stale), 32'd0);
    apply_vec(vecs[3], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
